// File: rtl/parking_gate_ctrl.sv
// Parking garage gate controller: edge-detected entry/exit
// requests, occupancy count with BCD readout, timed doors.
module parking_gate_ctrl #(
  parameter int CAPACITY  = 50,
  parameter int CNT_W     = 6,
  parameter int DOOR_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             park_in,
  input  logic             park_out,
  output logic             door_in,
  output logic             door_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             reject_full,
  output logic             reject_empty,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
);

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } gate_t;

  localparam logic [7:0] HOLD_LD =
    8'(DOOR_HOLD - 1);
  localparam logic [CNT_W-1:0] CAP =
    CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  logic             park_in_q;
  logic             park_out_q;
  gate_t            in_st;
  gate_t            in_st_n;
  gate_t            out_st;
  gate_t            out_st_n;
  logic [7:0]       in_hold;
  logic [7:0]       in_hold_n;
  logic [7:0]       out_hold;
  logic [7:0]       out_hold_n;
  logic             in_req;
  logic             out_req;
  logic             in_acc;
  logic             out_acc;
  logic             rej_full_n;
  logic             rej_empty_n;
  logic [CNT_W-1:0] count_n;
  logic [7:0]       cnt8;

  // Rising-edge detection on both sensors.
  always_comb begin
    in_req  = park_in & ~park_in_q;
    out_req = park_out & ~park_out_q;
  end

  // Accept/reject decisions and next occupancy.
  always_comb begin
    out_acc = out_req && (out_st == IDLE)
              && (count != '0);
    in_acc  = in_req && (in_st == IDLE)
              && ((count != CAP) || out_acc);
    rej_full_n = in_req && (in_st == IDLE)
                 && (count == CAP) && !out_acc;
    rej_empty_n = out_req && (out_st == IDLE)
                  && (count == '0);
    count_n = count;
    if (in_acc && !out_acc)
      count_n = count + ONE;
    else if (out_acc && !in_acc)
      count_n = count - ONE;
  end

  // Entry gate FSM: open for DOOR_HOLD cycles per accept.
  always_comb begin
    in_st_n   = in_st;
    in_hold_n = in_hold;
    unique case (in_st)
      IDLE: begin
        if (in_acc) begin
          in_st_n   = OPEN;
          in_hold_n = HOLD_LD;
        end
      end
      OPEN: begin
        if (in_hold == 8'd0)
          in_st_n = IDLE;
        else
          in_hold_n = in_hold - 8'd1;
      end
      default: in_st_n = IDLE;
    endcase
  end

  // Exit gate FSM: open for DOOR_HOLD cycles per accept.
  always_comb begin
    out_st_n   = out_st;
    out_hold_n = out_hold;
    unique case (out_st)
      IDLE: begin
        if (out_acc) begin
          out_st_n   = OPEN;
          out_hold_n = HOLD_LD;
        end
      end
      OPEN: begin
        if (out_hold == 8'd0)
          out_st_n = IDLE;
        else
          out_hold_n = out_hold - 8'd1;
      end
      default: out_st_n = IDLE;
    endcase
  end

  // BCD digits from next count so they land with count.
  always_comb begin
    cnt8 = 8'(count_n);
  end

  // State and registered outputs; reset wins over requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      park_in_q    <= 1'b1;
      park_out_q   <= 1'b1;
      in_st        <= IDLE;
      out_st       <= IDLE;
      in_hold      <= 8'd0;
      out_hold     <= 8'd0;
      door_in      <= 1'b0;
      door_out     <= 1'b0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      reject_full  <= 1'b0;
      reject_empty <= 1'b0;
      bcd_tens     <= 4'd0;
      bcd_ones     <= 4'd0;
    end else begin
      park_in_q    <= park_in;
      park_out_q   <= park_out;
      in_st        <= in_st_n;
      out_st       <= out_st_n;
      in_hold      <= in_hold_n;
      out_hold     <= out_hold_n;
      door_in      <= (in_st_n == OPEN);
      door_out     <= (out_st_n == OPEN);
      count        <= count_n;
      full         <= (count_n == CAP);
      empty        <= (count_n == '0);
      reject_full  <= rej_full_n;
      reject_empty <= rej_empty_n;
      bcd_tens     <= 4'(cnt8 / 8'd10);
      bcd_ones     <= 4'(cnt8 % 8'd10);
    end
  end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter CAPACITY, default 50, maximum number of cars; legal range 1..99.
REQ-002 Parameter CNT_W, default 6, width of count; SHALL satisfy 2**CNT_W > CAPACITY.
REQ-003 Parameter DOOR_HOLD, default 8, cycles a door stays open per accepted car; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 park_in  input  1  entry sensor, level; a 0->1 transition is one entry request.
REQ-007 park_out  input  1  exit sensor, level; a 0->1 transition is one exit request.
REQ-008 door_in  output  1  entry door open, registered.
REQ-009 door_out  output  1  exit door open, registered.
REQ-010 count  output  CNT_W  cars currently inside, registered.
REQ-011 full  output  1  high iff count == CAPACITY, registered.
REQ-012 empty  output  1  high iff count == 0, registered.
REQ-013 reject_full  output  1  one-cycle pulse, entry request refused because garage full.
REQ-014 reject_empty  output  1  one-cycle pulse, exit request refused because garage empty.
REQ-015 bcd_tens, bcd_ones  output  4 each  BCD digits of count, registered, same cycle as count.

Function
REQ-016 Edge detect: park_in_q/park_out_q hold previous-cycle sensor values; in_req = park_in & ~park_in_q, out_req = park_out & ~park_out_q.
REQ-017 Held-high sensors SHALL generate no further requests; one car per 0->1 transition.
REQ-018 Each gate has an independent FSM: IDLE -> OPEN on accept; OPEN holds DOOR_HOLD cycles via down-counter; OPEN -> IDLE when hold expires.
REQ-019 door_in/door_out SHALL be high exactly while the corresponding FSM is OPEN: from the cycle after the accepting edge for DOOR_HOLD consecutive cycles.
REQ-020 Requests arriving while that gate is OPEN SHALL be dropped silently: no count change, no reject pulse, no door extension.
REQ-021 Exit accept = out_req & exit IDLE & count != 0.
REQ-022 Entry accept = in_req & entry IDLE & (count != CAPACITY | exit accept in same cycle).
REQ-023 Count next: +1 if entry accept only; -1 if exit accept only; unchanged if both or neither.
REQ-024 Count SHALL never exceed CAPACITY nor go below 0; no wrap-around.
REQ-025 Latency: count, full, empty, bcd_* SHALL reflect an accept one cycle after the accepting edge, same cycle door rises.
REQ-026 reject_full pulses one cycle when in_req, entry IDLE, count == CAPACITY and no exit accept.
REQ-027 reject_empty pulses one cycle when out_req, exit IDLE and count == 0 (also when entry accepted same cycle).
REQ-028 bcd_tens = count / 10, bcd_ones = count % 10, both computed from next-count so they align with count.

Reset
REQ-029 Reset SHALL drive count=0, empty=1, full=0, door_in=0, door_out=0, reject_*=0, bcd_*=0, both FSMs IDLE, hold counters 0.
REQ-030 Reset SHALL set park_in_q=1 and park_out_q=1, so a sensor held high through reset yields no request.
REQ-031 Reset asserted mid-OPEN SHALL close the door the next cycle and discard any pending hold.
REQ-032 Reset SHALL take priority over all requests in the same cycle.

Verification
REQ-033 Reset, then one park_in pulse -> count=1, empty=0, door_in high exactly 8 cycles, bcd 0/1.
REQ-034 park_in held high 100 cycles -> count=1 only; second pulse during OPEN dropped, no reject.
REQ-035 50 spaced entry pulses -> count=50, full=1, bcd 5/0; 51st pulse -> reject_full one cycle, count stays 50, door_in stays low.
REQ-036 At count=50, simultaneous park_in and park_out edges -> both doors open, count stays 50, no reject.
REQ-037 At count=0, park_out pulse -> reject_empty one cycle, door_out low, count 0; simultaneous in+out at 0 -> count=1, reject_empty pulses.
REQ-038 Reset asserted 3 cycles into door_in OPEN with park_in held high -> door_in 0, count 0, no new entry after reset release.
